mdr_buffer: RTL and testbench

MDR_BUFFER -- requirements
Module: mdr_buffer

---
 rtl/mdr_pkg.sv | 18 +
 rtl/mdr_storage.sv | 80 ++++++++
 rtl/mdr_buffer.sv | 99 +++++++++
 tb/tb_mdr_buffer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mdr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdr_pkg
// Description : Shared constants and the count-width helper for mdr_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package mdr_pkg;

    localparam int c_default_width = 16;
    localparam int c_default_depth = 4;

    // Occupancy spans 0..DEPTH+1 (storage plus the output register).
    function automatic int count_width(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdr_storage.sv
`default_nettype none
// ============================================================================
// Module      : mdr_storage
// Description : Circular storage queue feeding the memory data register.
// Revision    : 1.0 - initial release
// ============================================================================
module mdr_storage
    import mdr_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int DEPTH = c_default_depth
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush_i,
    input  logic                          push_i,
    input  logic [WIDTH-1:0]              wr_data_i,
    input  logic                          pop_i,
    output logic [WIDTH-1:0]              head_data_o,
    output logic                          empty_o,
    output logic                          full_o,
    output logic [count_width(DEPTH)-1:0] occ_o
);

    localparam int CW = count_width(DEPTH);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    occ_q, occ_d;
    logic             w_push;
    logic             w_pop;

    assign empty_o     = (occ_q == '0);
    assign full_o      = (occ_q == CW'(DEPTH));
    assign occ_o       = occ_q;
    assign head_data_o = mem_q[rd_ptr_q];

    assign w_push = push_i && !flush_i && !full_o;
    assign w_pop  = pop_i  && !flush_i && !empty_o;

    // DEPTH is a power of two, so pointer increments wrap DEPTH-1 -> 0 naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (w_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({w_push, w_pop})
                2'b10:   occ_d = occ_q + CW'(1);
                2'b01:   occ_d = occ_q - CW'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule
`default_nettype wire

// File: rtl/mdr_buffer.sv
`default_nettype none
// ============================================================================
// Module      : mdr_buffer
// Description : Memory data register with a circular storage queue behind it.
//               Define MDR_BUFFER_BYPASS_EN for a one-edge push-to-output path.
// Revision    : 1.0 - initial release
// ============================================================================
module mdr_buffer
    import mdr_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int DEPTH = c_default_depth
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int CW = count_width(DEPTH);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] w_head;
    logic             w_st_empty;
    logic             w_st_full;
    logic [CW-1:0]    w_st_occ;
    logic             w_push;
    logic             w_pop;
    logic             w_bypass;
    logic             w_reload;

    // in_ready depends only on registered storage occupancy.
    assign in_ready  = !w_st_full;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign count     = w_st_occ + CW'(out_valid_q);

    assign w_push   = in_valid && in_ready;
    assign w_pop    = out_valid_q && out_ready;
    assign w_reload = (!out_valid_q || w_pop) && !w_st_empty;

`ifdef MDR_BUFFER_BYPASS_EN
    assign w_bypass = w_push && w_st_empty && (!out_valid_q || w_pop);
`else
    assign w_bypass = 1'b0;
`endif

    mdr_storage #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_storage (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (flush),
        .push_i      (w_push && !w_bypass),
        .wr_data_i   (in_data),
        .pop_i       (w_reload),
        .head_data_o (w_head),
        .empty_o     (w_st_empty),
        .full_o      (w_st_full),
        .occ_o       (w_st_occ)
    );

    // Flush empties the register but keeps its data (MDR hold).
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (w_bypass) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
        end else if (w_reload) begin
            out_valid_d = 1'b1;
            out_data_d  = w_head;
        end else if (w_pop) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdr_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdr_buffer
// Description : Directed self-checking bench for mdr_buffer (WIDTH=16, DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdr_buffer;

`ifdef MDR_BUFFER_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  count;

    int n_checks = 0;
    int n_errors = 0;
    int sent;
    int recv;

    mdr_buffer #(
        .WIDTH (16),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        step();
        step();
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_data",  64'(out_data),  64'd0);
        check("reset count",     64'(count),     64'd0);
        check("reset in_ready",  64'(in_ready),  64'd1);
        reset = 1'b0;
        step();

        // Single push latency
        in_valid = 1'b1;
        in_data  = 16'h1234;
        step();
        in_valid = 1'b0;
        check("single edge1 out_valid", 64'(out_valid), 64'(LAT == 1));
        check("single edge1 count", 64'(count), 64'd1);
        if (LAT == 2) step();
        check("single out_valid", 64'(out_valid), 64'd1);
        check("single out_data",  64'(out_data),  64'h1234);
        check("single count",     64'(count),     64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("single pop out_valid", 64'(out_valid), 64'd0);
        check("single pop hold data", 64'(out_data),  64'h1234);
        check("single pop count",     64'(count),     64'd0);

        // Fill to DEPTH+1 then drain in order
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 16'hA000 + 16'(i);
            check("fill in_ready", 64'(in_ready), 64'd1);
            step();
            check("fill count", 64'(count), 64'(i + 1));
        end
        check("full in_ready", 64'(in_ready), 64'd0);
        in_data = 16'hDEAD;
        step();
        in_valid = 1'b0;
        check("push while full count", 64'(count), 64'd5);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("drain out_valid", 64'(out_valid), 64'd1);
            check("drain out_data",  64'(out_data),  64'(16'hA000 + 16'(i)));
            step();
            check("drain count", 64'(count), 64'(4 - i));
        end
        check("drained out_valid", 64'(out_valid), 64'd0);
        check("drained hold data", 64'(out_data),  64'hA004);

        // Sustained streaming of 100 words
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 130 && recv < 100; cyc++) begin
            in_valid = (sent < 100);
            in_data  = 16'h0100 + 16'(sent);
            if (recv > 0) check("stream no bubble", 64'(out_valid), 64'd1);
            if (out_valid) begin
                check("stream order", 64'(out_data), 64'(16'h0100 + 16'(recv)));
                recv++;
            end
            if (sent >= 3 && sent < 100) check("stream steady count", 64'(count), 64'(LAT));
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid = 1'b0;
        check("stream received all", 64'(recv), 64'd100);
        check("stream end count", 64'(count), 64'd0);
        out_ready = 1'b0;

        // Flush beats a simultaneous push and pop
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 16'hB000 + 16'(i);
            step();
        end
        in_valid = 1'b0;
        if (LAT == 2) step();
        check("pre-flush count",    64'(count),    64'd3);
        check("pre-flush out_data", 64'(out_data), 64'hB000);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'hBEEF;
        out_ready = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush count",     64'(count),     64'd0);
        check("flush out_valid", 64'(out_valid), 64'd0);
        check("flush out_data",  64'(out_data),  64'hB000);
        step();
        step();
        check("flush no ghost out_valid", 64'(out_valid), 64'd0);
        check("flush no ghost count",     64'(count),     64'd0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hC001;
        step();
        in_valid = 1'b0;
        if (LAT == 2) step();
        check("post-flush out_data", 64'(out_data), 64'hC001);
        check("post-flush count",    64'(count),    64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("post-flush drain count", 64'(count), 64'd0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 16'hD000 + 16'(i);
            step();
        end
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("async reset out_valid", 64'(out_valid), 64'd0);
        check("async reset out_data",  64'(out_data),  64'd0);
        check("async reset count",     64'(count),     64'd0);
        check("async reset in_ready",  64'(in_ready),  64'd1);
        step();
        reset = 1'b0;
        step();
        in_valid = 1'b1;
        in_data  = 16'h00FF;
        step();
        in_valid = 1'b0;
        if (LAT == 2) step();
        check("after reset out_valid", 64'(out_valid), 64'd1);
        check("after reset out_data",  64'(out_data),  64'h00FF);
        check("after reset count",     64'(count),     64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("after reset drain", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
